// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory and decode-side handshakes of fetch_ctrl
interface fetch_ctrl_if;
  logic        imem_req, imem_ack, imem_rvalid, f2d_valid, f2d_rdy;
  logic [31:0] imem_addr, imem_rdata, f2d_instr, f2d_pc;
  modport master (
    output imem_req, imem_addr, f2d_valid, f2d_instr, f2d_pc,
    input  imem_ack, imem_rvalid, imem_rdata, f2d_rdy
  );
  modport slave (
    input  imem_req, imem_addr, f2d_valid, f2d_instr, f2d_pc,
    output imem_ack, imem_rvalid, imem_rdata, f2d_rdy
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: credit-limited instruction fetch with in-order response queue and flush discard
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         cpu_halt,
  input  logic         pipe_flush,
  input  logic [31:0]  rld_pc_addr,
  fetch_ctrl_if.master bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(QDEPTH);
  logic [31:0]   pc, rpc, redirect;
  logic [CW-1:0] out_cnt, drop_cnt, q_cnt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   q_instr [QDEPTH];
  logic [31:0]   q_pc [QDEPTH];
  logic          req_fire, rsp, push, pop;
  assign bus.imem_req  = !cpu_halt && !pipe_flush && (({1'b0, out_cnt} + {1'b0, q_cnt}) < DEPTH);
  assign bus.imem_addr = pc;
  assign bus.f2d_valid = q_cnt != 0;
  assign bus.f2d_instr = q_instr[rd_ptr];
  assign bus.f2d_pc    = q_pc[rd_ptr];
  // a response with nothing outstanding is illegal and ignored
  assign rsp      = bus.imem_rvalid && out_cnt != 0;
  assign req_fire = bus.imem_req && bus.imem_ack;
  assign push     = rsp && drop_cnt == 0 && !pipe_flush;
  assign pop      = bus.f2d_valid && bus.f2d_rdy && !pipe_flush;
  assign redirect = {rld_pc_addr[31:2], 2'b00};
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      pc       <= RESET_PC;
      rpc      <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      q_cnt    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      pc       <= pipe_flush ? redirect : req_fire ? pc + 32'd4 : pc;
      rpc      <= pipe_flush ? redirect : push ? rpc + 32'd4 : rpc;
      out_cnt  <= out_cnt + CW'(req_fire) - CW'(rsp);
      // on flush everything still in flight becomes a response to throw away
      drop_cnt <= pipe_flush ? out_cnt - CW'(rsp) : drop_cnt - CW'(rsp && drop_cnt != 0);
      q_cnt    <= pipe_flush ? '0 : q_cnt + CW'(push) - CW'(pop);
      rd_ptr   <= pipe_flush ? '0 : rd_ptr + AW'(pop);
      wr_ptr   <= pipe_flush ? '0 : wr_ptr + AW'(push);
    end
  always_ff @(posedge clk_in)
    if (push) begin
      q_instr[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]    <= rpc;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset (bits [1:0] are 0).
REQ-002 SHALL have parameter QDEPTH, default 4, meaning instruction queue depth (power of 2, >=2).
REQ-003 SHALL have port clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_in  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_halt  input  1  1 = issue no new memory requests.
REQ-006 SHALL have port pipe_flush  input  1  1 = redirect fetch and discard all queued and in-flight instructions.
REQ-007 SHALL have port rld_pc_addr  input  32  redirect target, sampled when pipe_flush=1.
REQ-008 SHALL have port imem_req  output  1  memory request valid.
REQ-009 SHALL have port imem_addr  output  32  request address, always word aligned.
REQ-010 SHALL have port imem_ack  input  1  request accepted this cycle when imem_req=1.
REQ-011 SHALL have port imem_rvalid  input  1  response valid; responses return in order, one per accepted request, at least 1 cycle after acceptance.
REQ-012 SHALL have port imem_rdata  input  32  response instruction.
REQ-013 SHALL have port f2d_valid  output  1  decode-side entry valid.
REQ-014 SHALL have port f2d_rdy  input  1  decode accepts head entry when f2d_valid=1.
REQ-015 SHALL have port f2d_instr  output  32  head instruction.
REQ-016 SHALL have port f2d_pc  output  32  address of f2d_instr.

Function
REQ-017 SHALL keep registers: fetch pc, response pc (rpc), outstanding count (out_cnt), discard count (drop_cnt), queue of QDEPTH {instr, pc} entries with count (q_cnt).
REQ-018 SHALL drive imem_req = !cpu_halt & !pipe_flush & (out_cnt + q_cnt < QDEPTH), imem_addr = pc (combinational from registers).
REQ-019 SHALL, on imem_req & imem_ack, increment pc by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0) and out_cnt by 1.
REQ-020 SHALL, on imem_rvalid with drop_cnt=0, push {imem_rdata, rpc} into queue, rpc += 4 modulo 2^32, out_cnt -= 1.
REQ-021 SHALL, on imem_rvalid with drop_cnt>0, discard response, drop_cnt -= 1, out_cnt -= 1, rpc unchanged.
REQ-022 SHALL never overflow the queue (guaranteed by REQ-018 credit rule); same-cycle push and pop SHALL leave q_cnt unchanged.
REQ-023 SHALL drive f2d_valid = (q_cnt != 0) and f2d_instr/f2d_pc from queue head; pop on f2d_valid & f2d_rdy.
REQ-024 SHALL hold f2d_instr/f2d_pc stable while f2d_valid=1 and f2d_rdy=0.
REQ-025 SHALL, on pipe_flush=1: pc <= {rld_pc_addr[31:2],2'b00}, rpc <= same, q_cnt <= 0, drop_cnt <= out_cnt minus 1 if imem_rvalid this cycle else out_cnt, out_cnt adjusted identically; response in the flush cycle discarded; no pop counted.
REQ-026 SHALL, on pipe_flush while drop_cnt>0, recompute drop_cnt per REQ-025 (all in-flight responses discarded).
REQ-027 SHALL have f2d_valid=0 in the cycle after pipe_flush.
REQ-028 SHALL, with cpu_halt=1, still accept responses and drain queue; only new requests are blocked.
REQ-029 SHALL keep out_cnt and drop_cnt within 0..QDEPTH; imem_rvalid with out_cnt=0 is illegal and SHALL be ignored.

Reset
REQ-030 SHALL, while reset_in=0, asynchronously set pc=rpc=RESET_PC, out_cnt=drop_cnt=q_cnt=0, so imem_req=0 if cpu_halt else 1, f2d_valid=0.
REQ-031 SHALL, on reset mid-operation, abandon in-flight requests; bench memory is also reset.

Verification
REQ-032 Reset release, cpu_halt=0, imem_ack=1, 1-cycle response, f2d_rdy=1 -> imem_addr 0,4,8,...; f2d_pc 0,4,8 in order, one per cycle after fill.
REQ-033 f2d_rdy=0 throughout, QDEPTH=4 -> exactly 4 requests accepted, imem_req then stays 0, f2d_pc=0 held stable.
REQ-034 Three requests outstanding, pipe_flush with rld_pc_addr=32'h0000_0102 -> next imem_addr=32'h100, the three responses discarded, first f2d_pc=32'h100.
REQ-035 Flush in same cycle as an imem_rvalid -> that response and remaining in-flight ones dropped; no stale f2d_pc appears.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000; f2d_pc matches.
REQ-037 cpu_halt=1 with 2 outstanding -> imem_req=0, both responses delivered to f2d in order.
